button_debounce_array: RTL and testbench

//  Parametrised NUM_CH-channel push-button conditioner: per-channel synchroniser, debounce filter,
//  and press/release edge pulses, plus long-press detect and optional auto-repeat.

---
 rtl/btn_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 131 +++++++++++++
 rtl/button_debounce_array.sv | 46 ++++
 tb/tb_button_debounce_array.sv | 133 +++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: hold-FSM encoding,
// counter width helpers and the default timing for the 100 MHz board build.
package btn_pkg;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_HOLD   = 2'd1,
    HS_REPEAT = 2'd2
  } hold_state_e;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 32;
  localparam int DEF_HOLD_CYC     = 5000;
  localparam int DEF_REPEAT_CYC   = 1000;

  // Bits needed for a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, consecutive-sample debounce filter,
// registered press/release pulses and the long-press / auto-repeat FSM.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int  DW     = cnt_w(DEBOUNCE_CYC);
  localparam int  HMAX   = max_i(HOLD_CYC, REPEAT_CYC);
  localparam int  HW     = cnt_w(HMAX);
  localparam bit  RPT_EN = (REPEAT_CYC > 0);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(RPT_EN ? REPEAT_CYC - 1 : 0);
  localparam logic [HW-1:0] HCNT_SAT  = HW'(HMAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   st_q, st_d;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   commit, press_ev, rel_ev;
  hold_state_e            hs_q, hs_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic                   press_q, rel_q, long_q, long_d, rpt_q, rpt_d;

  assign s        = sync_q[SYNC_STAGES-1];
  assign commit   = (s != st_q) && (db_cnt_q == DB_LAST);
  assign press_ev = commit & s;
  assign rel_ev   = commit & ~s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      st_q     <= 1'b0;
      db_cnt_q <= '0;
      hs_q     <= HS_IDLE;
      hcnt_q   <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
      rpt_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      st_q     <= st_d;
      db_cnt_q <= db_cnt_d;
      hs_q     <= hs_d;
      hcnt_q   <= hcnt_d;
      press_q  <= press_ev;
      rel_q    <= rel_ev;
      long_q   <= long_d;
      rpt_q    <= rpt_d;
    end
  end

  // Filter: any sample matching the current level restarts the count.
  always_comb begin
    st_d     = st_q;
    db_cnt_d = db_cnt_q;
    if (s == st_q) begin
      db_cnt_d = '0;
    end else if (commit) begin
      st_d     = s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  // Hold FSM reacts to the debounce decision of this same edge, so a
  // release landing on the threshold edge suppresses long/repeat.
  always_comb begin
    hs_d   = hs_q;
    hcnt_d = hcnt_q;
    long_d = 1'b0;
    rpt_d  = 1'b0;
    if (rel_ev) begin
      hs_d   = HS_IDLE;
      hcnt_d = '0;
    end else begin
      case (hs_q)
        HS_IDLE: begin
          if (press_ev) begin
            hs_d   = HS_HOLD;
            hcnt_d = '0;
          end
        end
        HS_HOLD: begin
          if (st_q && hcnt_q == HOLD_LAST) begin
            long_d = 1'b1;
            hcnt_d = '0;
            hs_d   = RPT_EN ? HS_REPEAT : HS_IDLE;
          end else if (hcnt_q != HCNT_SAT) begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        HS_REPEAT: begin
          if (hcnt_q == RPT_LAST) begin
            rpt_d  = 1'b1;
            hcnt_d = '0;
          end else if (hcnt_q != HCNT_SAT) begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: begin
          hs_d   = HS_IDLE;
          hcnt_d = '0;
        end
      endcase
    end
  end

  assign state_o   = st_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
  assign repeat_o  = rpt_q;

endmodule

// File: rtl/button_debounce_array.sv
// NUM_CH-channel push-button conditioner; applies optional pin inversion and
// packs the independent per-channel conditioners onto the output buses.
module button_debounce_array
  import btn_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] btn_i,
  output logic [NUM_CH-1:0] state_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] long_o,
  output logic [NUM_CH-1:0] repeat_o
);

  logic [NUM_CH-1:0] btn_pos;

  // Normalise to 1 = pressed before the synchroniser.
  assign btn_pos = ACTIVE_LOW ? ~btn_i : btn_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .btn_i    (btn_pos[g]),
      .state_o  (state_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench: two instances (active-high with repeat, active-low without)
// checked edge by edge against hand-derived pulse positions.
module tb_button_debounce_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_a, btn_b;
  logic [1:0] st_a, pr_a, rl_a, lg_a, rp_a;
  logic [1:0] st_b, pr_b, rl_b, lg_b, rp_b;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_debounce_array #(
    .NUM_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .HOLD_CYC(10),
    .REPEAT_CYC(3), .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_a), .state_o(st_a),
    .press_o(pr_a), .release_o(rl_a), .long_o(lg_a), .repeat_o(rp_a)
  );

  button_debounce_array #(
    .NUM_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .HOLD_CYC(10),
    .REPEAT_CYC(0), .ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_b), .state_o(st_b),
    .press_o(pr_b), .release_o(rl_b), .long_o(lg_b), .repeat_o(rp_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [1:0] st, pr, rl, lg, rp);
    chk({tag, " a.state"},   32'(st_a), 32'(st));
    chk({tag, " a.press"},   32'(pr_a), 32'(pr));
    chk({tag, " a.release"}, 32'(rl_a), 32'(rl));
    chk({tag, " a.long"},    32'(lg_a), 32'(lg));
    chk({tag, " a.repeat"},  32'(rp_a), 32'(rp));
  endtask

  task automatic chk_b(input string tag, input logic [1:0] st, pr, rl, lg, rp);
    chk({tag, " b.state"},   32'(st_b), 32'(st));
    chk({tag, " b.press"},   32'(pr_b), 32'(pr));
    chk({tag, " b.release"}, 32'(rl_b), 32'(rl));
    chk({tag, " b.long"},    32'(lg_b), 32'(lg));
    chk({tag, " b.repeat"},  32'(rp_b), 32'(rp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    btn_a = 2'b00;
    btn_b = 2'b11;

    // 1: asynchronous reset between edges, then released with idle pins
    #2 rst_n = 1'b0;
    #1;
    chk_a("t1 rst", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_b("t1 rst", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_a($sformatf("t1 e%0d", i), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      chk_b($sformatf("t1 e%0d", i), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // 2+4: clean press at edge 6, long at 16, repeats every 3, release at 32
    btn_a = 2'b01;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk_a($sformatf("t2 e%0d", i),
            {1'b0, (i >= 6 && i < 32)},
            {1'b0, (i == 6)},
            {1'b0, (i == 32)},
            {1'b0, (i == 16)},
            {1'b0, (i == 19 || i == 22 || i == 25 || i == 28 || i == 31)});
      if (i == 26) btn_a = 2'b00;
    end

    // 3+5: bounce delays press to edge 10; release commits at 20 = threshold edge
    btn_a = 2'b01;
    for (int j = 1; j <= 24; j++) begin
      tick();
      chk_a($sformatf("t3 e%0d", j),
            {1'b0, (j >= 10 && j < 20)},
            {1'b0, (j == 10)},
            {1'b0, (j == 20)},
            2'b00, 2'b00);
      btn_a[0] = !((j + 1) == 4 || (j + 1) >= 15);
    end

    // 5b: next press restarts the hold count from zero
    btn_a = 2'b01;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk_a($sformatf("t5 e%0d", k),
            {1'b0, (k >= 6)}, {1'b0, (k == 6)}, 2'b00, {1'b0, (k == 16)}, 2'b00);
    end
    btn_a = 2'b00;
    repeat (8) tick();

    // 6: active-low pin held low, no auto-repeat
    btn_b = 2'b10;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk_b($sformatf("t6 e%0d", k),
            {1'b0, (k >= 6)}, {1'b0, (k == 6)}, 2'b00, {1'b0, (k == 16)}, 2'b00);
    end
    rst_n = 1'b0;
    #1;
    chk_b("t6 rst", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk_a("t6 rst", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    repeat (2) tick();
    chk_b("t6 rst held", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
